sccb_target_responder: RTL

//  SCCB/I2C target (responder) with an internal 8-bit register file; the counterpart of the SoC's camera-control

---
 rtl/sccb_pkg.sv | 23 ++
 rtl/sccb_input_filter.sv | 51 +++++
 rtl/sccb_target_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB target responder: protocol state encoding,
// acknowledge levels and the default device address.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } sccbState_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h21;

endpackage

// File: rtl/sccb_input_filter.sv
// Brings one asynchronous bus line into the systemClock domain, rejects glitches
// shorter than FILTER_CYCLES samples and flags the accepted rising/falling edges.
module sccb_input_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic systemClock,
  input  logic nReset,
  input  logic lineIn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [1:0]       syncReg;
  logic [CNT_W-1:0] cntReg;
  logic             levelReg;
  logic             riseReg;
  logic             fallReg;

  // Idle bus level is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge systemClock or negedge nReset) begin
    if (!nReset) begin
      syncReg  <= 2'b11;
      cntReg   <= '0;
      levelReg <= 1'b1;
      riseReg  <= 1'b0;
      fallReg  <= 1'b0;
    end else begin
      syncReg <= {syncReg[0], lineIn};
      riseReg <= 1'b0;
      fallReg <= 1'b0;
      if (syncReg[1] == levelReg) begin
        cntReg <= '0;
      end else if (cntReg == CNT_W'(FILTER_CYCLES - 1)) begin
        cntReg   <= '0;
        levelReg <= syncReg[1];
        riseReg  <= syncReg[1];
        fallReg  <= ~syncReg[1];
      end else begin
        cntReg <= cntReg + 1'b1;
      end
    end
  end

  assign level = levelReg;
  assign rise  = riseReg;
  assign fall  = fallReg;

endmodule

// File: rtl/sccb_target_responder.sv
// SCCB/I2C target with an internal 8-bit register file: byte writes and reads with
// register-pointer auto-increment, plus a registered side-band host read port.
module sccb_target_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR   = DEFAULT_DEVICE_ADDR,
  parameter int         REG_DEPTH     = 256,
  parameter int         FILTER_CYCLES = 3
) (
  input  logic       systemClock,
  input  logic       nReset,
  input  logic       scl,
  input  logic       sdaIn,
  output logic       sdaDriven,
  input  logic [7:0] hostAddr,
  output logic [7:0] hostData,
  output logic       writeStrobe,
  output logic [7:0] writeAddr,
  output logic [7:0] writeData,
  output logic       busy
);

  logic [1:0] lineRaw, lineLevel, lineRise, lineFall;
  assign lineRaw = {sdaIn, scl};

  for (genvar gi = 0; gi < 2; gi++) begin : gInputFilter
    sccb_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) uFilter (
      .systemClock(systemClock),
      .nReset     (nReset),
      .lineIn     (lineRaw[gi]),
      .level      (lineLevel[gi]),
      .rise       (lineRise[gi]),
      .fall       (lineFall[gi])
    );
  end

  logic sclF, sclRise, sclFall, sdaF, sdaRise, sdaFall;
  assign sclF    = lineLevel[0];
  assign sclRise = lineRise[0];
  assign sclFall = lineFall[0];
  assign sdaF    = lineLevel[1];
  assign sdaRise = lineRise[1];
  assign sdaFall = lineFall[1];

  sccbState_t stateReg, stateNext;
  logic [3:0] bitCntReg, bitCntNext;
  logic [7:0] shiftReg, shiftNext;
  logic [7:0] regPtrReg, regPtrNext;
  logic       rwReg, rwNext;
  logic       sdaDrivenReg, sdaDrivenNext;
  logic       busyReg, busyNext;
  logic       writeStrobeReg, writeStrobeNext;
  logic [7:0] writeAddrReg, writeAddrNext;
  logic [7:0] writeDataReg, writeDataNext;
  logic       regWriteEn;
  logic [7:0] byteIn;
  logic [7:0] readByte;
  logic [7:0] hostDataReg;

  logic [7:0] regFile [REG_DEPTH];

  assign byteIn   = {shiftReg[6:0], sdaF};
  assign readByte = (int'(regPtrReg) < REG_DEPTH) ? regFile[regPtrReg] : 8'hFF;

  always_ff @(posedge systemClock or negedge nReset) begin
    if (!nReset) begin
      stateReg       <= IDLE;
      bitCntReg      <= '0;
      shiftReg       <= '0;
      regPtrReg      <= '0;
      rwReg          <= 1'b0;
      sdaDrivenReg   <= 1'b0;
      busyReg        <= 1'b0;
      writeStrobeReg <= 1'b0;
      writeAddrReg   <= '0;
      writeDataReg   <= '0;
    end else begin
      stateReg       <= stateNext;
      bitCntReg      <= bitCntNext;
      shiftReg       <= shiftNext;
      regPtrReg      <= regPtrNext;
      rwReg          <= rwNext;
      sdaDrivenReg   <= sdaDrivenNext;
      busyReg        <= busyNext;
      writeStrobeReg <= writeStrobeNext;
      writeAddrReg   <= writeAddrNext;
      writeDataReg   <= writeDataNext;
    end
  end

  // In the *_ACK states bitCnt marks which SCL fall we are on: 0 = start driving, 1 = release.
  always_comb begin
    stateNext       = stateReg;
    bitCntNext      = bitCntReg;
    shiftNext       = shiftReg;
    regPtrNext      = regPtrReg;
    rwNext          = rwReg;
    sdaDrivenNext   = sdaDrivenReg;
    busyNext        = busyReg;
    writeStrobeNext = 1'b0;
    writeAddrNext   = writeAddrReg;
    writeDataNext   = writeDataReg;
    regWriteEn      = 1'b0;

    if (sclF && sdaFall) begin
      stateNext     = ADDR;
      bitCntNext    = '0;
      sdaDrivenNext = 1'b0;
    end else if (sclF && sdaRise) begin
      stateNext     = IDLE;
      bitCntNext    = '0;
      sdaDrivenNext = 1'b0;
      busyNext      = 1'b0;
    end else begin
      case (stateReg)
        ADDR, REG, WDATA: begin
          if (sclRise) begin
            shiftNext  = byteIn;
            bitCntNext = bitCntReg + 4'd1;
            if (bitCntReg == 4'd7) begin
              bitCntNext = '0;
              if (stateReg == ADDR) begin
                if (byteIn[7:1] == DEVICE_ADDR) begin
                  stateNext = ADDR_ACK;
                  busyNext  = 1'b1;
                  rwNext    = byteIn[0];
                end else begin
                  stateNext = IGNORE;
                  busyNext  = 1'b0;
                end
              end else if (stateReg == REG) begin
                regPtrNext = byteIn;
                stateNext  = REG_ACK;
              end else begin
                regWriteEn      = 1'b1;
                writeStrobeNext = 1'b1;
                writeAddrNext   = regPtrReg;
                writeDataNext   = byteIn;
                regPtrNext      = regPtrReg + 8'd1;
                stateNext       = WDATA_ACK;
              end
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (sclFall) begin
            if (bitCntReg == 4'd0) begin
              sdaDrivenNext = 1'b1;
              bitCntNext    = 4'd1;
            end else begin
              sdaDrivenNext = 1'b0;
              bitCntNext    = '0;
              if (stateReg == ADDR_ACK && rwReg) begin
                stateNext     = RDATA;
                shiftNext     = readByte;
                sdaDrivenNext = ~readByte[7];
              end else if (stateReg == ADDR_ACK) begin
                stateNext = REG;
              end else begin
                stateNext = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (sclRise) begin
            bitCntNext = bitCntReg + 4'd1;
          end else if (sclFall) begin
            if (bitCntReg == 4'd8) begin
              sdaDrivenNext = 1'b0;
              bitCntNext    = '0;
              stateNext     = RDATA_ACK;
            end else begin
              shiftNext     = {shiftReg[6:0], 1'b0};
              sdaDrivenNext = ~shiftReg[6];
            end
          end
        end
        RDATA_ACK: begin
          if (sclRise && bitCntReg == 4'd0) begin
            regPtrNext = regPtrReg + 8'd1;
            if (sdaF == NACK) begin
              stateNext = IGNORE;
              busyNext  = 1'b0;
            end else begin
              bitCntNext = 4'd1;
            end
          end else if (sclFall && bitCntReg == 4'd1) begin
            bitCntNext    = '0;
            stateNext     = RDATA;
            shiftNext     = readByte;
            sdaDrivenNext = ~readByte[7];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : gRegFile
    always_ff @(posedge systemClock or negedge nReset) begin
      if (!nReset) begin
        regFile[gi] <= '0;
      end else if (regWriteEn && regPtrReg == 8'(gi)) begin
        regFile[gi] <= byteIn;
      end
    end
  end

  always_ff @(posedge systemClock or negedge nReset) begin
    if (!nReset) begin
      hostDataReg <= '0;
    end else begin
      hostDataReg <= (int'(hostAddr) < REG_DEPTH) ? regFile[hostAddr] : 8'hFF;
    end
  end

  assign sdaDriven   = sdaDrivenReg;
  assign busy        = busyReg;
  assign writeStrobe = writeStrobeReg;
  assign writeAddr   = writeAddrReg;
  assign writeData   = writeDataReg;
  assign hostData    = hostDataReg;

endmodule
